// File: rtl/trap_controller.sv
// ---------------------------------------------------------------------------
// trap_controller
//   Branch / exception / interrupt arbitration for the Kabeta pipeline.
//   Picks the next-PC source every cycle, produces the trap vector address,
//   flushes and acknowledges pipeline stages, and acknowledges interrupt
//   lines. Interrupts are synchronised through two flops and are held off
//   for HOLD_CYC cycles after every dispatch. Exceptions are never held off.
//
//   Ports
//     Clock        in   system clock, rising edge
//     SysReset     in   asynchronous active-low reset
//     ExcReq       in   per-stage exception request (bit0 = IF)
//     ExcCode      in   per-stage 3-bit code, stage s at [3s+2:3s]
//     Stall        in   load-use stall from the hazard unit
//     Supervisor   in   supervisor mode, masks interrupts
//     IRQ          in   asynchronous interrupt lines, active high
//     BrCond       in   branch condition (`BRC_*) of the branch in BR_STG
//     Ra           in   branch test operand
//     ExcAddr      out  vector address, meaningful when PC_Sel == `PCS_EXCA
//     PC_Sel       out  next-PC mux select (`PCS_*)
//     Flush        out  per-stage flush
//     ExcAck       out  per-stage exception accepted (stage saves its PC)
//     ReplicatePC  out  taken-branch PC replicate
//     IrqAck       out  one-hot pulse on interrupt dispatch
//
//   Build option
//     TRAP_IRQ_EDGE_EN  defined: a synchronised rising edge latches a pending
//                       bit that is held until acknowledged.
//                       undefined: pending is the synchronised level, nothing
//                       is latched and IrqAck is informative only.
// ---------------------------------------------------------------------------

`ifndef PCS_PCNX
`define PCS_PCNX  2'd0
`endif
`ifndef PCS_PCLIT
`define PCS_PCLIT 2'd1
`endif
`ifndef PCS_REGA
`define PCS_REGA  2'd2
`endif
`ifndef PCS_EXCA
`define PCS_EXCA  2'd3
`endif

`ifndef BRC_NV
`define BRC_NV 2'd0
`endif
`ifndef BRC_EQ
`define BRC_EQ 2'd1
`endif
`ifndef BRC_NE
`define BRC_NE 2'd2
`endif
`ifndef BRC_AL
`define BRC_AL 2'd3
`endif

module trap_controller #(
  parameter int          NUM_STG    = 4,
  parameter int          BR_STG     = 1,
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
  parameter int          VEC_STRIDE = 4,
  parameter int          HOLD_CYC   = 3
) (
  input  logic                 Clock,
  input  logic                 SysReset,
  input  logic [NUM_STG-1:0]   ExcReq,
  input  logic [3*NUM_STG-1:0] ExcCode,
  input  logic                 Stall,
  input  logic                 Supervisor,
  input  logic [NUM_IRQ-1:0]   IRQ,
  input  logic [1:0]           BrCond,
  input  logic [31:0]          Ra,
  output logic [31:0]          ExcAddr,
  output logic [1:0]           PC_Sel,
  output logic [NUM_STG-1:0]   Flush,
  output logic [NUM_STG-1:0]   ExcAck,
  output logic                 ReplicatePC,
  output logic [NUM_IRQ-1:0]   IrqAck
);

  localparam int STG_W = (NUM_STG > 1) ? $clog2(NUM_STG) : 1;
  localparam int IRQ_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
  // Stages 0..BR_STG: flushed by a taken branch; also the "shallow" stages
  // whose exceptions yield to branch and stall.
  localparam logic [NUM_STG-1:0] BR_FLUSH  = NUM_STG'((1 << (BR_STG + 1)) - 1);
  // Stages 0..BR_STG+1: flushed on interrupt entry.
  localparam logic [NUM_STG-1:0] IRQ_FLUSH = NUM_STG'((1 << (BR_STG + 2)) - 1);
  // The stage right after branch resolution: bubbled on stall, and the stage
  // whose PC is saved on interrupt entry.
  localparam logic [NUM_STG-1:0] DRAIN_BIT = NUM_STG'(1 << (BR_STG + 1));

  typedef enum logic [1:0] {
    RST_VEC = 2'd0,
    IDLE    = 2'd1,
    HOLD    = 2'd2
  } trapState_t;

  trapState_t         stateR;
  trapState_t         stateNxtS;
  logic [CNT_W-1:0]   holdCntR;
  logic [CNT_W-1:0]   holdCntNxtS;
  logic [NUM_IRQ-1:0] irqMetaR;
  logic [NUM_IRQ-1:0] irqSyncR;
  logic [NUM_IRQ-1:0] pendingS;

  logic               brTakenS;
  logic [NUM_STG-1:0] excReqS;
  logic               excHitS;
  logic [STG_W-1:0]   excStgS;
  logic [NUM_STG-1:0] codeLsbS;
  logic               irqGoS;
  logic [IRQ_W-1:0]   irqIdxS;
  logic               trapS;
  logic               unusedCodeBits;

  // Only the LSB of each stage code selects the vector; the rest is reserved.
  assign unusedCodeBits = ^ExcCode;

  // Index of the highest set request bit (deepest stage).
  function automatic logic [STG_W-1:0] deepestStage(input logic [NUM_STG-1:0] req);
    logic [STG_W-1:0] idx;
    idx = '0;
    for (int s = 0; s < NUM_STG; s++) begin
      if (req[s]) begin
        idx = STG_W'(s);
      end
    end
    return idx;
  endfunction

  // Index of the lowest set interrupt bit.
  function automatic logic [IRQ_W-1:0] lowestIrq(input logic [NUM_IRQ-1:0] req);
    logic [IRQ_W-1:0] idx;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IRQ_W'(i);
      end
    end
    return idx;
  endfunction

  // Mask with bits 0..stg set.
  function automatic logic [NUM_STG-1:0] thruMask(input logic [STG_W-1:0] stg);
    logic [NUM_STG-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_STG; i++) begin
      m[i] = (i <= int'(stg));
    end
    return m;
  endfunction

  // Vector table entry address for a slot number.
  function automatic logic [31:0] vecAddr(input int slot);
    return VEC_BASE + 32'(VEC_STRIDE * slot);
  endfunction

  // Gather the vector-select bit (code LSB) of every stage.
  always_comb begin
    codeLsbS = '0;
    for (int s = 0; s < NUM_STG; s++) begin
      codeLsbS[s] = ExcCode[3*s];
    end
  end

  // Two-flop synchroniser for the asynchronous interrupt lines.
  always_ff @(posedge Clock or negedge SysReset) begin
    if (!SysReset) begin
      irqMetaR <= '0;
      irqSyncR <= '0;
    end else begin
      irqMetaR <= IRQ;
      irqSyncR <= irqMetaR;
    end
  end

`ifdef TRAP_IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] irqPrevR;
  logic [NUM_IRQ-1:0] pendR;
  logic [NUM_IRQ-1:0] riseS;
  logic [NUM_IRQ-1:0] pendNxtS;

  // Edge-latched pending: a fresh edge is visible the cycle it is seen.
  // When an older pending bit is acknowledged while a new edge arrives, the
  // new edge survives the acknowledge.
  always_comb begin
    riseS    = irqSyncR & ~irqPrevR;
    pendingS = pendR | riseS;
    pendNxtS = (~IrqAck & pendingS) | (IrqAck & pendR & riseS);
  end

  // Edge-detect history and pending latch.
  always_ff @(posedge Clock or negedge SysReset) begin
    if (!SysReset) begin
      irqPrevR <= '0;
      pendR    <= '0;
    end else begin
      irqPrevR <= irqSyncR;
      pendR    <= pendNxtS;
    end
  end
`else
  // Level-sensitive: pending simply follows the synchronised lines.
  always_comb begin
    pendingS = irqSyncR;
  end
`endif

  // Request qualification: shallow exceptions yield to a taken branch or a
  // stall (the instruction may be squashed or replayed).
  always_comb begin
    brTakenS = (BrCond == `BRC_AL)
             | ((BrCond == `BRC_EQ) & (Ra == 32'd0))
             | ((BrCond == `BRC_NE) & (Ra != 32'd0));
    excReqS  = (brTakenS | Stall) ? (ExcReq & ~BR_FLUSH) : ExcReq;
    excHitS  = |excReqS;
    excStgS  = deepestStage(excReqS);
    irqGoS   = (stateR == IDLE) & ~Supervisor & (|pendingS);
    irqIdxS  = lowestIrq(pendingS);
  end

  // Priority decision: exception, interrupt, stall, branch, sequential.
  always_comb begin
    PC_Sel      = `PCS_PCNX;
    ExcAddr     = VEC_BASE;
    Flush       = '0;
    ExcAck      = '0;
    ReplicatePC = 1'b0;
    IrqAck      = '0;
    trapS       = 1'b0;
    if (stateR == RST_VEC) begin
      PC_Sel = `PCS_EXCA;
    end else if (excHitS) begin
      PC_Sel  = `PCS_EXCA;
      ExcAddr = vecAddr(1 + 2 * int'(excStgS) + int'(codeLsbS[excStgS]));
      Flush   = thruMask(excStgS);
      ExcAck  = NUM_STG'(1) << excStgS;
      trapS   = 1'b1;
    end else if (irqGoS) begin
      PC_Sel  = `PCS_EXCA;
      ExcAddr = vecAddr(1 + 2 * NUM_STG + int'(irqIdxS));
      Flush   = IRQ_FLUSH;
      ExcAck  = DRAIN_BIT;
      IrqAck  = NUM_IRQ'(1) << irqIdxS;
      trapS   = 1'b1;
    end else if (Stall) begin
      Flush = DRAIN_BIT;
    end else if (brTakenS) begin
      PC_Sel      = (BrCond == `BRC_AL) ? `PCS_REGA : `PCS_PCLIT;
      Flush       = BR_FLUSH;
      ReplicatePC = 1'b1;
    end else begin
      PC_Sel = `PCS_PCNX;
    end
  end

  // Sequencing: reset vector, then idle; any dispatch (re)starts the holdoff.
  always_comb begin
    stateNxtS   = stateR;
    holdCntNxtS = holdCntR;
    case (stateR)
      RST_VEC: begin
        stateNxtS   = IDLE;
        holdCntNxtS = '0;
      end
      IDLE: begin
        if (trapS) begin
          stateNxtS   = HOLD;
          holdCntNxtS = HOLD_LOAD;
        end else begin
          stateNxtS   = IDLE;
        end
      end
      HOLD: begin
        if (trapS) begin
          stateNxtS   = HOLD;
          holdCntNxtS = HOLD_LOAD;
        end else if (holdCntR == '0) begin
          stateNxtS   = IDLE;
        end else begin
          holdCntNxtS = holdCntR - CNT_W'(1);
        end
      end
      default: begin
        stateNxtS   = RST_VEC;
        holdCntNxtS = '0;
      end
    endcase
  end

  // FSM state and holdoff counter.
  always_ff @(posedge Clock or negedge SysReset) begin
    if (!SysReset) begin
      stateR   <= RST_VEC;
      holdCntR <= '0;
    end else begin
      stateR   <= stateNxtS;
      holdCntR <= holdCntNxtS;
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller (default build, level-sensitive IRQ).
// The driver applies inputs just after each rising edge, asks the reference
// model what the DUT must show this cycle and queues it; the monitor pops
// and compares on every falling edge.
module tb_trap_controller;

  localparam int          NUM_STG    = 4;
  localparam int          BR_STG     = 1;
  localparam int          NUM_IRQ    = 4;
  localparam logic [31:0] VEC_BASE   = 32'h0000_0000;
  localparam int          VEC_STRIDE = 4;
  localparam int          HOLD_CYC   = 3;

  localparam logic [1:0] PCNX  = 2'd0;
  localparam logic [1:0] PCLIT = 2'd1;
  localparam logic [1:0] REGA  = 2'd2;
  localparam logic [1:0] EXCA  = 2'd3;
  localparam logic [1:0] B_NV  = 2'd0;
  localparam logic [1:0] B_EQ  = 2'd1;
  localparam logic [1:0] B_NE  = 2'd2;
  localparam logic [1:0] B_AL  = 2'd3;

  logic        Clock = 1'b1;
  logic        SysReset;
  logic [3:0]  ExcReq;
  logic [11:0] ExcCode;
  logic        Stall;
  logic        Supervisor;
  logic [3:0]  IRQ;
  logic [1:0]  BrCond;
  logic [31:0] Ra;
  logic [31:0] ExcAddr;
  logic [1:0]  PC_Sel;
  logic [3:0]  Flush;
  logic [3:0]  ExcAck;
  logic        ReplicatePC;
  logic [3:0]  IrqAck;

  trap_controller #(
    .NUM_STG(NUM_STG), .BR_STG(BR_STG), .NUM_IRQ(NUM_IRQ),
    .VEC_BASE(VEC_BASE), .VEC_STRIDE(VEC_STRIDE), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .Clock(Clock), .SysReset(SysReset), .ExcReq(ExcReq), .ExcCode(ExcCode),
    .Stall(Stall), .Supervisor(Supervisor), .IRQ(IRQ), .BrCond(BrCond),
    .Ra(Ra), .ExcAddr(ExcAddr), .PC_Sel(PC_Sel), .Flush(Flush),
    .ExcAck(ExcAck), .ReplicatePC(ReplicatePC), .IrqAck(IrqAck)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [1:0]  pcSel;
    logic [31:0] addr;
    logic [3:0]  flush;
    logic [3:0]  ack;
    logic        rep;
    logic [3:0]  irqAck;
  } exp_t;

  exp_t       expQ[$];
  int         errors = 0;
  int         checks = 0;

  // Reference model state
  bit         mRstVec = 1'b1;   // first cycle after reset release
  int         mHold   = 0;      // cycles left during which IRQs are blocked
  logic [3:0] irqSeen[$];       // IRQ values sampled at edges since reset

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected outputs for the current inputs, then advance the model one edge.
  task automatic model();
    exp_t       e;
    logic       taken;
    logic [3:0] pend;
    int         stg;
    int         irqI;
    e.pcSel = PCNX; e.addr = VEC_BASE; e.flush = 4'd0; e.ack = 4'd0;
    e.rep = 1'b0; e.irqAck = 4'd0;
    if (SysReset == 1'b0) begin
      e.pcSel = EXCA;
      mRstVec = 1'b1;
      mHold   = 0;
      irqSeen.delete();
    end else if (mRstVec) begin
      e.pcSel = EXCA;
      mRstVec = 1'b0;
      irqSeen.push_back(IRQ);
    end else begin
      taken = (BrCond == B_AL) || (BrCond == B_EQ && Ra == 32'd0) ||
              (BrCond == B_NE && Ra != 32'd0);
      pend  = (irqSeen.size() >= 2) ? irqSeen[irqSeen.size()-2] : 4'd0;
      stg = -1;
      for (int s = NUM_STG - 1; s > BR_STG; s--)
        if (ExcReq[s] && stg < 0) stg = s;
      if (stg < 0 && !taken && !Stall)
        for (int s = BR_STG; s >= 0; s--)
          if (ExcReq[s] && stg < 0) stg = s;
      irqI = -1;
      if (mHold == 0 && !Supervisor)
        for (int i = NUM_IRQ - 1; i >= 0; i--)
          if (pend[i]) irqI = i;
      if (stg >= 0) begin
        e.pcSel = EXCA;
        e.addr  = VEC_BASE + 32'(VEC_STRIDE * (1 + 2 * stg + int'(ExcCode[3*stg])));
        e.flush = 4'((1 << (stg + 1)) - 1);
        e.ack   = 4'(1 << stg);
        mHold   = HOLD_CYC;
      end else if (irqI >= 0) begin
        e.pcSel  = EXCA;
        e.addr   = VEC_BASE + 32'(VEC_STRIDE * (1 + 2 * NUM_STG + irqI));
        e.flush  = 4'((1 << (BR_STG + 2)) - 1);
        e.ack    = 4'(1 << (BR_STG + 1));
        e.irqAck = 4'(1 << irqI);
        mHold    = HOLD_CYC;
      end else begin
        if (Stall) begin
          e.flush = 4'(1 << (BR_STG + 1));
        end else if (taken) begin
          e.pcSel = (BrCond == B_AL) ? REGA : PCLIT;
          e.flush = 4'((1 << (BR_STG + 1)) - 1);
          e.rep   = 1'b1;
        end
        if (mHold > 0) mHold--;
      end
      irqSeen.push_back(IRQ);
      if (irqSeen.size() > 2) void'(irqSeen.pop_front());
    end
    expQ.push_back(e);
  endtask

  task automatic cycle(input int n);
    for (int k = 0; k < n; k++) begin
      model();
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic quiet();
    ExcReq = 4'd0; ExcCode = 12'd0; Stall = 1'b0; Supervisor = 1'b0;
    BrCond = B_NV; Ra = 32'd0;
  endtask

  // Monitor: compare whatever the DUT shows against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("pc_sel", 32'(PC_Sel), 32'(e.pcSel));
        check("flush", 32'(Flush), 32'(e.flush));
        check("exc_ack", 32'(ExcAck), 32'(e.ack));
        check("replicate", 32'(ReplicatePC), 32'(e.rep));
        check("irq_ack", 32'(IrqAck), 32'(e.irqAck));
        if (e.pcSel == EXCA) check("exc_addr", ExcAddr, e.addr);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] code;
    SysReset = 1'b0; IRQ = 4'd0;
    quiet();
    cycle(3);
    // Reset release: one reset-vector cycle, then sequential fetch
    SysReset = 1'b1;
    cycle(4);

    // Deepest exception wins over a shallower one
    code = 12'($urandom()); code[9] = 1'b0;
    ExcReq = 4'b1010; ExcCode = code;
    cycle(1);
    quiet();
    cycle(4);

    // Branch in RR beats the RR exception; stall beats the branch
    ExcReq = 4'b0010; ExcCode = 12'h008; BrCond = B_AL; Ra = $urandom();
    cycle(1);
    Stall = 1'b1;
    cycle(1);
    quiet();
    cycle(2);

    // Interrupts: IRQ1 then IRQ2 after holdoff, then masked by supervisor
    IRQ = 4'b0110;
    cycle(3);
    IRQ = 4'b0100;
    cycle(6);
    Supervisor = 1'b1;
    cycle(5);
    IRQ = 4'b0000; Supervisor = 1'b0;
    cycle(5);

    // Branch conditions
    BrCond = B_EQ; Ra = 32'd0; cycle(1);
    Ra = 32'd5;                cycle(1);
    BrCond = B_NE;             cycle(1);
    Ra = 32'd0;                cycle(1);
    BrCond = B_NV;             cycle(1);
    quiet();

    // Reset in the middle of a holdoff with an IRQ pending
    IRQ = 4'b0001;
    cycle(4);
    SysReset = 1'b0;
    cycle(2);
    SysReset = 1'b1;
    cycle(6);
    IRQ = 4'b0000;
    cycle(3);

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      for (int b = 0; b < NUM_STG; b++) ExcReq[b] = ($urandom_range(0, 7) == 0);
      ExcCode    = 12'($urandom());
      Stall      = ($urandom_range(0, 5) == 0);
      Supervisor = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) IRQ = 4'($urandom());
      BrCond     = 2'($urandom());
      Ra         = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom();
      SysReset   = ($urandom_range(0, 99) != 0);
      cycle(1);
    end

    @(negedge Clock);
    check("queue_drained", 32'(expQ.size()), 32'd0);
    if (checks < 12) begin
      errors++;
      $display("FAIL check_count: got %0d expected at least 12", checks);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
